regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor to the PE general-purpose register file. Adds configurable width and depth, a hardwired zero register, and write-to-read bypass. Adds a per-register busy scoreboard that stalls reads of registers with pending writes, plus a valid/ready read handshake with a registered response. It sits between decode (reserve, read requests) and writeback (writes) in the RISC-V PE.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of 2, at least 2)
ADDR_W, $clog2(NUM_REGS), register index width (derived)
ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes and reserves
BYPASS, 1, when 1, a same-cycle write is forwarded to the read sampled in that cycle

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write enable (writeback)
wr_addr  in  ADDR_W  destination register
wr_data  in  DATA_W  write data
rsv_en  in  1  reserve: mark rsv_addr busy (pending write)
rsv_addr  in  ADDR_W  register to reserve
rd_req_valid  in  1  read request valid
rd_req_ready  out  1  read request accepted when valid&ready
rd_both  in  1  0: read rs1 only; 1: read rs1 and rs2
rs1_addr  in  ADDR_W  source register 1
rs2_addr  in  ADDR_W  source register 2
rd_resp_valid  out  1  one-cycle pulse, data valid
rd_data1  out  DATA_W  rs1 value
rd_data2  out  DATA_W  rs2 value (0 when rd_both=0)
busy_vec  out  NUM_REGS  current scoreboard bits

Behaviour:
- Reset (reset=0, async): all registers 0, busy_vec 0, FSM to IDLE; rd_req_ready=0 while reset is asserted; rd_resp_valid=0, rd_data1/2=0. Reset mid-stall or mid-response drops the request silently.
- FSM states: IDLE, WAIT, RESP.
- IDLE: rd_req_ready=1. On valid&ready, latch rs1/rs2/rd_both.
  - If no sourced register is blocked: sample data, go to RESP.
  - Otherwise go to WAIT.
- WAIT: rd_req_ready=0. Re-evaluate the blocked condition on the latched addresses each cycle. When clear, sample data and go to RESP.
- RESP: rd_resp_valid=1 for exactly one cycle, rd_req_ready=0. Next state is IDLE. Data holds its value until the next response.
- Latency: 1 cycle from acceptance to rd_resp_valid with no stall; 1 + stall cycles otherwise. Maximum throughput is one read per 2 cycles.
- Blocked condition: a sourced register is busy AND not written this cycle. A register that is being written this cycle counts as clear when BYPASS=1.
  - Only rs1 is a sourced register when rd_both=0.
  - Register 0 is never blocked when ZERO_REG=1.
- Data sampling: a register's value is wr_data if BYPASS=1, wr_en=1 and wr_addr matches it; otherwise the array value.
  - With BYPASS=0, a write is visible from the following cycle. A busy register therefore stays blocked until the cycle after its write.
- Write: wr_en=1 updates the array on the clock edge and clears busy[wr_addr]. A write to a non-busy register is legal and performs an ordinary update.
- Reserve: rsv_en=1 sets busy[rsv_addr] on the clock edge.
- Reserve and write to the same register in the same cycle: the data is written and busy ends 1 (the new reservation wins).
- Reserve and write to different registers: both take effect.
- ZERO_REG=1: register 0 reads 0, and writes and reserves to it are ignored (busy_vec[0] stays 0). ZERO_REG=0: register 0 is an ordinary register.
- The rd_both=0 response drives rd_data2=0.
- Inputs are sampled only in the accepting cycle; changes to rs*_addr or rd_both during WAIT/RESP have no effect.
- No back-pressure on the response: the consumer must take the rd_resp_valid pulse.

Test Plan:
- Reset then read x5 with rd_both=1: rd_req_ready=1, resp 1 cycle after accept, data1=data2=0, busy_vec=0.
- Write x3=0xDEADBEEF, next cycle read rs1=x3, rs2=x0 with rd_both=1: data1=0xDEADBEEF, data2=0. Write x0=0x1234 then read x0: 0.
- Reserve x7, read rs1=x7: FSM stalls in WAIT, rd_resp_valid=0 for 4 cycles. Write x7=0xA5 on cycle 4 (BYPASS=1): rd_resp_valid pulses the next cycle with data1=0xA5 and busy_vec[7]=0. Repeat with BYPASS=0: response is one cycle later.
- Same-cycle write and reserve of x9=0x55: busy_vec[9] stays 1, array holds 0x55, a read of x9 stalls until the next write.
- rd_both=0 with rs2 busy: no stall, data2=0.
- Assert reset during a WAIT stall: outputs 0 immediately. After release, FSM is IDLE, rd_req_ready=1 and no response is issued.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bus of the scoreboarded register file: write port,
// reserve port, read request/response handshake and the busy vector.
interface regfile_scoreboard_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic              rd_both;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
           rd_req_valid, rd_both, rs1_addr, rs2_addr,
    input  rd_req_ready, rd_resp_valid, rd_data1, rd_data2, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
           rd_req_valid, rd_both, rs1_addr, rs2_addr,
    output rd_req_ready, rd_resp_valid, rd_data1, rd_data2, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with a per-register busy scoreboard. Reads are
// accepted through a valid/ready handshake, stall while a sourced register
// has a pending write, and return through a registered one-cycle response.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W-1:0]   r_rs1;
  logic [ADDR_W-1:0]   r_rs2;
  logic                r_both;
  logic                r_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_data1;
  logic [DATA_W-1:0]   r_data2;

  logic                w_wr_ok;
  logic                w_rsv_ok;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_src1;
  logic [ADDR_W-1:0]   w_src2;
  logic                w_both;
  logic                w_fwd1;
  logic                w_fwd2;
  logic                w_blocked;
  logic [DATA_W-1:0]   w_val1;
  logic [DATA_W-1:0]   w_val2;

  function automatic logic f_is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Register 0 swallows writes and reserves when it is hardwired.
  assign w_wr_ok  = bus.wr_en  && !f_is_zero(bus.wr_addr);
  assign w_rsv_ok = bus.rsv_en && !f_is_zero(bus.rsv_addr);
  assign w_accept = bus.rd_req_valid && r_ready;

  // The request is evaluated on live inputs in the accepting cycle and on the
  // latched copy while stalled.
  assign w_src1 = (r_state == S_IDLE) ? bus.rs1_addr : r_rs1;
  assign w_src2 = (r_state == S_IDLE) ? bus.rs2_addr : r_rs2;
  assign w_both = (r_state == S_IDLE) ? bus.rd_both  : r_both;

  // Blocked test and operand selection, including same-cycle write forwarding.
  always_comb begin
    w_fwd1    = (BYPASS != 0) && w_wr_ok && (bus.wr_addr == w_src1);
    w_fwd2    = (BYPASS != 0) && w_wr_ok && (bus.wr_addr == w_src2);
    w_blocked = (r_busy[w_src1] && !w_fwd1) ||
                (w_both && r_busy[w_src2] && !w_fwd2);
    w_val1    = f_is_zero(w_src1) ? '0 : (w_fwd1 ? bus.wr_data : r_mem[w_src1]);
    w_val2    = f_is_zero(w_src2) ? '0 : (w_fwd2 ? bus.wr_data : r_mem[w_src2]);
  end

  // Array write and scoreboard update; a same-cycle reserve overrides the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[bus.wr_addr]  <= bus.wr_data;
        r_busy[bus.wr_addr] <= 1'b0;
      end
      if (w_rsv_ok) r_busy[bus.rsv_addr] <= 1'b1;
    end
  end

  // Read handshake FSM with registered ready, response pulse and data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_data1      <= '0;
      r_data2      <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_both       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rs1   <= bus.rs1_addr;
            r_rs2   <= bus.rs2_addr;
            r_both  <= bus.rd_both;
            r_ready <= 1'b0;
            if (!w_blocked) begin
              r_data1      <= w_val1;
              r_data2      <= w_both ? w_val2 : '0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_state <= S_WAIT;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!w_blocked) begin
            r_data1      <= w_val1;
            r_data2      <= w_both ? w_val2 : '0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_req_ready  = r_ready;
  assign bus.rd_resp_valid = r_resp_valid;
  assign bus.rd_data1      = r_data1;
  assign bus.rd_data2      = r_data2;
  assign bus.busy_vec      = r_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (bypass + hardwired x0, and
// no bypass + ordinary x0) share one stimulus stream. A reference model of the
// architectural state predicts each response into a queue; a monitor pops and
// compares on every response pulse.
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_scoreboard_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) if0 (), if1 ();

  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1))
    u_dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0))
    u_dut1 (.clk(clk), .reset(rst_n), .bus(if1));

  // Shared stimulus
  logic          s_we, s_re, s_v, s_both;
  logic [AW-1:0] s_wa, s_ra, s_a1, s_a2;
  logic [DW-1:0] s_wd;

  assign if0.wr_en = s_we;   assign if1.wr_en = s_we;
  assign if0.wr_addr = s_wa; assign if1.wr_addr = s_wa;
  assign if0.wr_data = s_wd; assign if1.wr_data = s_wd;
  assign if0.rsv_en = s_re;  assign if1.rsv_en = s_re;
  assign if0.rsv_addr = s_ra; assign if1.rsv_addr = s_ra;
  assign if0.rd_req_valid = s_v; assign if1.rd_req_valid = s_v;
  assign if0.rd_both = s_both;   assign if1.rd_both = s_both;
  assign if0.rs1_addr = s_a1;    assign if1.rs1_addr = s_a1;
  assign if0.rs2_addr = s_a2;    assign if1.rs2_addr = s_a2;

  logic          o_rdy [2];
  logic          o_rv  [2];
  logic [DW-1:0] o_d1  [2];
  logic [DW-1:0] o_d2  [2];
  logic [NR-1:0] o_busy[2];
  assign o_rdy[0] = if0.rd_req_ready;   assign o_rdy[1] = if1.rd_req_ready;
  assign o_rv[0]  = if0.rd_resp_valid;  assign o_rv[1]  = if1.rd_resp_valid;
  assign o_d1[0]  = if0.rd_data1;       assign o_d1[1]  = if1.rd_data1;
  assign o_d2[0]  = if0.rd_data2;       assign o_d2[1]  = if1.rd_data2;
  assign o_busy[0] = if0.busy_vec;      assign o_busy[1] = if1.busy_vec;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", nm, k, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [DW-1:0] d1; logic [DW-1:0] d2; int cyc; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic [DW-1:0] m_mem [2][NR];
  logic [NR-1:0] m_busy [2];
  bit            m_pend [2];
  bit            m_rdy  [2];
  bit            m_lboth[2];
  int            m_l1   [2];
  int            m_l2   [2];

  logic [DW-1:0] last_d1 [2];
  logic [DW-1:0] last_d2 [2];
  int            last_cyc[2] = '{-1, -1};

  function automatic bit has_byp(input int k); return k == 0; endfunction
  function automatic bit has_zr (input int k); return k == 0; endfunction

  function automatic bit m_wr_ok(input int k);
    return s_we && !(has_zr(k) && s_wa == 0);
  endfunction
  function automatic bit m_fwd(input int k, input int a);
    return has_byp(k) && m_wr_ok(k) && (int'(s_wa) == a);
  endfunction
  function automatic bit m_blocked(input int k, input int a);
    if (has_zr(k) && a == 0) return 1'b0;
    return m_busy[k][a] && !m_fwd(k, a);
  endfunction
  function automatic logic [DW-1:0] m_val(input int k, input int a);
    if (has_zr(k) && a == 0) return '0;
    if (m_fwd(k, a)) return s_wd;
    return m_mem[k][a];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NR; r++) m_mem[k][r] = '0;
      m_busy[k] = '0; m_pend[k] = 0; m_rdy[k] = 0;
      m_lboth[k] = 0; m_l1[k] = 0; m_l2[k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One cycle of architectural behaviour given the current stimulus.
  task automatic m_step(input int k);
    bit   consider = 0;
    bit   issued   = 0;
    exp_t e;
    if (s_v && m_rdy[k]) begin
      m_l1[k] = int'(s_a1); m_l2[k] = int'(s_a2); m_lboth[k] = s_both;
      consider = 1;
    end else if (m_pend[k]) begin
      consider = 1;
    end
    if (consider) begin
      if (m_blocked(k, m_l1[k]) || (m_lboth[k] && m_blocked(k, m_l2[k]))) begin
        m_pend[k] = 1;
      end else begin
        e.d1  = m_val(k, m_l1[k]);
        e.d2  = m_lboth[k] ? m_val(k, m_l2[k]) : '0;
        e.cyc = cyc + 1;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        m_pend[k] = 0;
        issued = 1;
      end
    end
    if (m_wr_ok(k)) begin
      m_mem[k][s_wa]  = s_wd;
      m_busy[k][s_wa] = 1'b0;
    end
    if (s_re && !(has_zr(k) && s_ra == 0)) m_busy[k][s_ra] = 1'b1;
    m_rdy[k] = !m_pend[k] && !issued;
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int k);
    exp_t e;
    bit   have;
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      if (k == 0) e = q0[0]; else e = q1[0];
    end
    if (o_rv[k]) begin
      if (!have) begin
        n_chk++;
        $display("FAIL resp_unexpected dut%0d: got rd_resp_valid=1 with no request outstanding (cycle %0d)", k, cyc);
      end else begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk("rd_data1", k, o_d1[k], e.d1);
        chk("rd_data2", k, o_d2[k], e.d2);
        chk("resp_cycle", k, cyc, e.cyc);
        last_d1[k] = o_d1[k]; last_d2[k] = o_d2[k]; last_cyc[k] = cyc;
      end
    end else if (have && e.cyc <= cyc) begin
      n_chk++;
      $display("FAIL resp_missing dut%0d: got no response at cycle %0d expected one at cycle %0d", k, cyc, e.cyc);
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                      input bit re, input int ra,
                      input bit v, input bit both, input int a1, input int a2);
    s_we = we; s_wa = AW'(wa); s_wd = wd;
    s_re = re; s_ra = AW'(ra);
    s_v = v; s_both = both; s_a1 = AW'(a1); s_a2 = AW'(a2);
    for (int k = 0; k < 2; k++) m_step(k);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("rd_req_ready", k, o_rdy[k], m_rdy[k]);
      chk("busy_vec", k, o_busy[k], m_busy[k]);
    end
  endtask

  task automatic idle(); step(0, 0, '0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input int a, input logic [DW-1:0] d); step(1, a, d, 0, 0, 0, 0, 0, 0); endtask
  task automatic rsv(input int a); step(0, 0, '0, 1, a, 0, 0, 0, 0); endtask
  task automatic rd(input bit both, input int a1, input int a2); step(0, 0, '0, 0, 0, 1, both, a1, a2); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

  initial begin
    int c;
    int c_rst;
    rst_n = 1'b0;
    s_we = 0; s_wa = '0; s_wd = '0; s_re = 0; s_ra = '0;
    s_v = 0; s_both = 0; s_a1 = '0; s_a2 = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("ready_in_reset", k, o_rdy[k], 0);
      chk("resp_in_reset", k, o_rv[k], 0);
    end
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < 2; k++) chk("ready_after_reset", k, o_rdy[k], 1);

    // Fresh read of x5, both operands
    c = cyc; rd(1, 5, 5); idle();
    for (int k = 0; k < 2; k++) begin
      chk("x5_data1", k, last_d1[k], 0);
      chk("x5_data2", k, last_d2[k], 0);
      chk("x5_latency", k, last_cyc[k], c + 1);
    end

    // Written value visible next cycle; x0 behaviour depends on ZERO_REG
    wr(3, 32'hDEADBEEF);
    rd(1, 3, 0); idle();
    for (int k = 0; k < 2; k++) begin
      chk("x3_data1", k, last_d1[k], 32'hDEADBEEF);
      chk("x3_data2", k, last_d2[k], 0);
    end
    wr(0, 32'h1234);
    rd(0, 0, 0); idle();
    chk("x0_hardwired", 0, last_d1[0], 0);
    chk("x0_ordinary", 1, last_d1[1], 32'h1234);

    // Stall on reserved x7, released by a write four cycles later
    rsv(7);
    for (int k = 0; k < 2; k++) chk("busy7_set", k, o_busy[k][7], 1);
    rd(0, 7, 0);
    idle(); idle(); idle();
    c = cyc; wr(7, 32'hA5); idle(); idle();
    chk("x7_release_bypass", 0, last_cyc[0], c + 1);
    chk("x7_release_nobypass", 1, last_cyc[1], c + 2);
    for (int k = 0; k < 2; k++) chk("x7_data1", k, last_d1[k], 32'hA5);

    // Same-cycle write and reserve of x9: reservation wins
    step(1, 9, 32'h55, 1, 9, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("busy9_kept", k, o_busy[k][9], 1);
    rd(0, 9, 0);
    idle(); idle(); idle();
    c = cyc; wr(9, 32'h66); idle(); idle();
    chk("x9_release_bypass", 0, last_cyc[0], c + 1);
    chk("x9_release_nobypass", 1, last_cyc[1], c + 2);
    for (int k = 0; k < 2; k++) chk("x9_data1", k, last_d1[k], 32'h66);

    // rs2 busy but unused: no stall
    rsv(10);
    c = cyc; rd(0, 3, 10); idle();
    for (int k = 0; k < 2; k++) begin
      chk("single_data1", k, last_d1[k], 32'hDEADBEEF);
      chk("single_data2", k, last_d2[k], 0);
      chk("single_latency", k, last_cyc[k], c + 1);
    end
    wr(10, 32'h1); idle();

    // Reset while stalled
    rsv(11);
    rd(0, 11, 0);
    idle();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", k, o_rdy[k], 0);
      chk("rst_resp_valid", k, o_rv[k], 0);
      chk("rst_data1", k, o_d1[k], 0);
      chk("rst_data2", k, o_d2[k], 0);
      chk("rst_busy", k, o_busy[k], 0);
    end
    m_reset();
    c_rst = cyc;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < 2; k++) chk("ready_after_midreset", k, o_rdy[k], 1);
    idle(); idle(); idle();
    for (int k = 0; k < 2; k++) chk("no_resp_after_reset", k, last_cyc[k] < c_rst, 1);

    // Randomized traffic on a small register window to force conflicts
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(1, 0) == 1, $urandom_range(7, 0), $urandom,
           $urandom_range(4, 0) == 0, $urandom_range(7, 0),
           $urandom_range(9, 0) < 7, $urandom_range(1, 0) == 1,
           $urandom_range(7, 0), $urandom_range(7, 0));
    end

    // Drain: write every register so any stalled read completes
    for (int r = 0; r < NR; r++) wr(r, $urandom);
    repeat (4) idle();
    chk("queue_drained", 0, q0.size(), 0);
    chk("queue_drained", 1, q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
